// File: rtl/useq_pkg.sv
// useq_pkg: shared types and constants for the microprogram sequencer.
// Holds state encoding, seq codes, field positions and next-address rule.
package useq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [1:0] SEQ_JMP = 2'b00;
    localparam logic [1:0] SEQ_BR  = 2'b01;
    localparam logic [1:0] SEQ_RST = 2'b10;
    localparam logic [1:0] SEQ_HLT = 2'b11;

    localparam int UNA_LSB = 0;
    localparam int SEQ_LSB = 6;

    // Low byte of the microword selects the successor address.
    function automatic logic [5:0] next_addr(
        input logic [7:0] lo,
        input logic [5:0] upc,
        input logic       c,
        input logic [5:0] sa
    );
        logic [5:0] una;
        logic [1:0] seq;
        una = lo[UNA_LSB +: 6];
        seq = lo[SEQ_LSB +: 2];
        unique case (seq)
            SEQ_JMP: next_addr = una;
            SEQ_BR:  next_addr = c ? una : upc + 6'd1;
            SEQ_RST: next_addr = sa;
            SEQ_HLT: next_addr = una;
        endcase
    endfunction

endpackage

// File: rtl/useq_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter, rising-edge pulse.
// The pulse is emitted in the cycle the debounced level goes high.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_100M,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;
    logic          pulse_q, pulse_d;

    // Count consecutive samples that differ from the debounced level.
    always_comb begin
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        pulse_d = 1'b0;
        if (sync_q[1] == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d   = '0;
            deb_d   = sync_q[1];
            pulse_d = sync_q[1];
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/useq_ctrl.sv
// useq_ctrl: microprogram sequencer for the 64x24 control-store ROM.
// Define USEQ_INSTCNT_EN to build the saturating uinst_cnt counter.
module useq_ctrl
    import useq_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int RUN_DIV    = 50_000_000,
    parameter int ROM_LAT    = 1
) (
    input  logic        clk_100M,
    input  logic        rst_n,
    input  logic        btn_step,
    input  logic        btn_load,
    input  logic        run,
    input  logic [5:0]  start_addr,
    input  logic        cond,
    output logic [5:0]  rom_addr,
    input  logic [23:0] rom_q,
    output logic [23:0] uword,
    output logic [5:0]  upc,
    output logic        halted,
    output logic        busy,
    output logic [15:0] uinst_cnt
);

    localparam int LW = $clog2(ROM_LAT + 1);
    localparam int PW = $clog2(RUN_DIV + 1);
    localparam logic [LW-1:0] LAT_END = LW'(ROM_LAT);
    localparam logic [PW-1:0] PRE_END = PW'(RUN_DIV - 1);

    state_e        state_q, state_d;
    logic [5:0]    addr_q, addr_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [23:0]   uword_q, uword_d;
    logic [5:0]    upc_q, upc_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          step_p, load_p;
    logic          run_tick, adv;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .btn_i    (btn_step),
        .pulse_o  (step_p)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .btn_i    (btn_load),
        .pulse_o  (load_p)
    );

    assign run_tick = run && (pre_q == PRE_END);
    assign adv      = run ? run_tick : step_p;

    // Free-run prescaler, parked at zero in single-step mode.
    always_comb begin
        pre_d = pre_q;
        if (!run || run_tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Sequencer next state: load overrides everything else.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        uword_d = uword_q;
        upc_d   = upc_q;
        if (load_p) begin
            addr_d  = start_addr;
            lat_d   = '0;
            state_d = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_FETCH: begin
                    if (lat_q == LAT_END) begin
                        uword_d = rom_q;
                        upc_d   = addr_q;
                        if (rom_q[SEQ_LSB +: 2] == SEQ_HLT) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (adv) begin
                        addr_d  = next_addr(uword_q[7:0], upc_q,
                                            cond, start_addr);
                        lat_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
                ST_HALT: begin
                end
            endcase
        end
    end

    // Sequencer and prescaler registers.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 6'h00;
            lat_q   <= '0;
            uword_q <= 24'h0;
            upc_q   <= 6'h00;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lat_q   <= lat_d;
            uword_q <= uword_d;
            upc_q   <= upc_d;
            pre_q   <= pre_d;
        end
    end

`ifdef USEQ_INSTCNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    logic        ucnt_inc;

    // Count advances taken from HOLD, sticking at all-ones.
    always_comb begin
        ucnt_inc = (state_q == ST_HOLD) && adv && !load_p;
        ucnt_d   = ucnt_q;
        if (ucnt_inc && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Instruction counter register, cleared only by reset.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= 16'h0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign uinst_cnt = ucnt_q;
`else
    assign uinst_cnt = 16'h0;
`endif

    assign rom_addr = addr_q;
    assign uword    = uword_q;
    assign upc      = upc_q;
    assign halted   = (state_q == ST_HALT);
    assign busy     = (state_q == ST_FETCH);

endmodule
